// File: rtl/ram_t0_arbiter.sv
// Two-requester, burst-bounded round-robin arbiter for the single-port tensor RAM ram_t0.
// Grants are combinational from the valids; read data returns one cycle later with a per-requester valid.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ram_t0_arbiter #(
    parameter int unsigned ADDR_W    = `ADDR_SIZE,
    parameter int unsigned DATA_W    = `DATA_WIDTH,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic              clka,
    input  logic              rst,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,

    output logic [DATA_W-1:0] rsp_data,

    output logic              ram_ena,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    input  logic [DATA_W-1:0] ram_douta
);

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    logic       owner;
    logic [3:0] cnt;
    logic [1:0] rd_pend;

    logic       gnt_any_c;
    logic       gnt_sel_c;
    logic       gnt_read_c;

    // Grant selection: a lone requester always wins; under contention the owner keeps the port until its burst is spent.
    always_comb begin
        gnt_any_c = 1'b0;
        gnt_sel_c = 1'b0;
        if (!rst) begin
            unique case ({req1_valid, req0_valid})
                2'b01: begin
                    gnt_any_c = 1'b1;
                    gnt_sel_c = 1'b0;
                end
                2'b10: begin
                    gnt_any_c = 1'b1;
                    gnt_sel_c = 1'b1;
                end
                2'b11: begin
                    gnt_any_c = 1'b1;
                    gnt_sel_c = (cnt >= BURST_LIM) ? ~owner : owner;
                end
                default: begin
                    gnt_any_c = 1'b0;
                    gnt_sel_c = 1'b0;
                end
            endcase
        end
    end

    // RAM port mux; all command fields are zero when nothing is granted.
    always_comb begin
        ram_ena   = gnt_any_c;
        ram_wea   = 1'b0;
        ram_addra = '0;
        ram_dina  = '0;
        if (gnt_any_c) begin
            ram_wea   = gnt_sel_c ? req1_we    : req0_we;
            ram_addra = gnt_sel_c ? req1_addr  : req0_addr;
            ram_dina  = gnt_sel_c ? req1_wdata : req0_wdata;
        end
    end

    assign gnt_read_c = gnt_any_c & ~ram_wea;

    assign req0_ready = gnt_any_c & ~gnt_sel_c;
    assign req1_ready = gnt_any_c &  gnt_sel_c;

    // Responses are suppressed while reset is held so a read issued just before reset never returns.
    assign rsp0_valid = rd_pend[0] & ~rst;
    assign rsp1_valid = rd_pend[1] & ~rst;
    assign rsp_data   = ram_douta;

    // Owner/burst tracking and read-return flags; idle cycles leave owner and cnt untouched.
    always_ff @(posedge clka) begin
        if (rst) begin
            owner   <= 1'b0;
            cnt     <= 4'd0;
            rd_pend <= 2'b00;
        end else begin
            rd_pend <= {gnt_read_c & gnt_sel_c, gnt_read_c & ~gnt_sel_c};
            if (gnt_any_c) begin
                if (gnt_sel_c == owner) begin
                    if (cnt < BURST_LIM) begin
                        cnt <= cnt + 4'd1;
                    end
                end else begin
                    owner <= gnt_sel_c;
                    cnt   <= 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_t0_arbiter.sv
// Bench for ram_t0_arbiter: two instances (BURST_MAX 4 and 1) share one stimulus stream and are
// checked every cycle against a grant-history model and a shadow memory.
module tb_ram_t0_arbiter;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 64;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic          rst  = 1'b1;
    logic          fill = 1'b1;
    logic          r0v = 1'b0, r0w = 1'b0, r1v = 1'b0, r1w = 1'b0;
    logic [AW-1:0] r0a = '0, r1a = '0;
    logic [DW-1:0] r0d = '0, r1d = '0;

    logic [1:0]    rdy0, rdy1, rv0, rv1, ena, wea;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] din  [2];
    logic [DW-1:0] dout [2];
    logic [DW-1:0] rdat [2];
    logic [DW-1:0] mem  [2][DEPTH];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        ram_t0_arbiter #(
            .ADDR_W   (AW),
            .DATA_W   (DW),
            .BURST_MAX((k == 0) ? 4 : 1)
        ) u_dut (
            .clka      (clka),
            .rst       (rst),
            .req0_valid(r0v),
            .req0_we   (r0w),
            .req0_addr (r0a),
            .req0_wdata(r0d),
            .req0_ready(rdy0[k]),
            .rsp0_valid(rv0[k]),
            .req1_valid(r1v),
            .req1_we   (r1w),
            .req1_addr (r1a),
            .req1_wdata(r1d),
            .req1_ready(rdy1[k]),
            .rsp1_valid(rv1[k]),
            .rsp_data  (rdat[k]),
            .ram_ena   (ena[k]),
            .ram_wea   (wea[k]),
            .ram_addra (addr[k]),
            .ram_dina  (din[k]),
            .ram_douta (dout[k])
        );
    end

    // Behavioural single-port RAM, one per instance, preloaded with a known pattern.
    always @(posedge clka) begin
        for (int k = 0; k < 2; k++) begin
            if (fill) begin
                for (int i = 0; i < DEPTH; i++) mem[k][i] <= DW'(i * 37 + 11);
            end else if (ena[k]) begin
                if (wea[k]) mem[k][addr[k]] <= din[k];
                dout[k] <= mem[k][addr[k]];
            end
        end
    end

    // Reference state: last granted requester, length of its current run, pending read.
    int            last [2];
    int            run  [2];
    int            pend [2];
    logic [DW-1:0] pdat [2];
    logic [DW-1:0] shadow [2][DEPTH];
    int            n_chk  = 0;
    int            n_fail = 0;

    function automatic int burst_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int exp_grant(input int k, input bit v0, input bit v1);
        if (!v0 && !v1) return -1;
        if (v0 && !v1)  return 0;
        if (!v0 && v1)  return 1;
        return (run[k] < burst_of(k)) ? last[k] : 1 - last[k];
    endfunction

    task automatic chk(input string tag, input int k, input int unsigned obs, input int unsigned exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[bm%0d]: observed %0h expected %0h", tag, burst_of(k), obs, exp);
        end
    endtask

    task automatic step(input bit v0, input bit w0, input int a0, input int d0,
                        input bit v1, input bit w1, input int a1, input int d1,
                        input bit r);
        int            g  [2];
        bit            ew [2];
        logic [AW-1:0] ea [2];
        logic [DW-1:0] ed [2];
        @(negedge clka);
        rst = r;
        r0v = v0; r0w = w0; r0a = AW'(a0); r0d = DW'(d0);
        r1v = v1; r1w = w1; r1a = AW'(a1); r1d = DW'(d1);
        #2;
        for (int k = 0; k < 2; k++) begin
            g[k]  = r ? -1 : exp_grant(k, v0, v1);
            ew[k] = (g[k] == 0) ? w0 : (g[k] == 1) ? w1 : 1'b0;
            ea[k] = (g[k] == 0) ? AW'(a0) : (g[k] == 1) ? AW'(a1) : AW'(0);
            ed[k] = (g[k] == 0) ? DW'(d0) : (g[k] == 1) ? DW'(d1) : DW'(0);
            chk("req0_ready", k, 32'(rdy0[k]), 32'(g[k] == 0));
            chk("req1_ready", k, 32'(rdy1[k]), 32'(g[k] == 1));
            chk("ram_ena",    k, 32'(ena[k]),  32'(g[k] >= 0));
            chk("ram_wea",    k, 32'(wea[k]),  32'(ew[k]));
            chk("ram_addra",  k, 32'(addr[k]), 32'(ea[k]));
            chk("ram_dina",   k, 32'(din[k]),  32'(ed[k]));
            chk("rsp0_valid", k, 32'(rv0[k]),  32'(!r && pend[k] == 0));
            chk("rsp1_valid", k, 32'(rv1[k]),  32'(!r && pend[k] == 1));
            if (!r && pend[k] >= 0) chk("rsp_data", k, 32'(rdat[k]), 32'(pdat[k]));
        end
        @(posedge clka);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                last[k] = 0;
                run[k]  = 0;
                pend[k] = -1;
            end else begin
                pend[k] = (g[k] >= 0 && !ew[k]) ? g[k] : -1;
                if (g[k] >= 0) begin
                    if (ew[k]) shadow[k][ea[k]] = ed[k];
                    else       pdat[k] = shadow[k][ea[k]];
                    if (g[k] == last[k]) run[k]++;
                    else begin
                        last[k] = g[k];
                        run[k]  = 1;
                    end
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            last[k] = 0; run[k] = 0; pend[k] = -1; pdat[k] = '0;
            for (int i = 0; i < DEPTH; i++) shadow[k][i] = DW'(i * 37 + 11);
        end
        @(negedge clka);
        fill = 1'b0;

        // Reset held two cycles with both requesters valid, then first contention.
        step(1, 0, 1, 0, 1, 0, 2, 0, 1);
        step(1, 0, 1, 0, 1, 0, 2, 0, 1);
        step(1, 0, 1, 0, 1, 0, 2, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Requester 0 write stream, requester 1 read-back stream.
        for (int i = 0; i < 8; i++) step(1, 1, i, 'hA0 + i, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 0, i, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Continuous contention with random commands from a clean reset.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++)
            step(1, 1'($urandom), $urandom, $urandom, 1, 1'($urandom), $urandom, $urandom, 0);

        // Contending reads only, so responses interleave between requesters.
        for (int i = 0; i < 16; i++)
            step(1, 0, $urandom, 0, 1, 0, $urandom, 0, 0);

        // Lone requester 1 beyond its burst, then requester 0 joins.
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 0, $urandom, 0, 0);
        for (int i = 0; i < 3; i++)  step(1, 0, $urandom, 0, 1, 0, $urandom, 0, 0);

        // Read accepted, then reset on the next edge; response must not appear.
        step(0, 0, 0, 0, 1, 0, 5, 0, 0);
        step(1, 0, 3, 0, 1, 0, 4, 0, 1);
        step(1, 0, 3, 0, 1, 0, 4, 0, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++)
            step(1'(($urandom % 4) != 0), 1'($urandom), $urandom, $urandom,
                 1'(($urandom % 4) != 0), 1'($urandom), $urandom, $urandom,
                 1'(($urandom % 40) == 0));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
